// File: rtl/player_pkg.sv
// Shared types for fifo_player: FSM states, word-space code, default widths.
package player_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        HOLD,
        GAP
    } state_t;

    localparam int         DEF_DATA_W = 4;
    localparam logic [3:0] SPACE_CODE = 4'hF;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with zero flag; saturates at zero.
module cycle_timer
    import player_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fifo_player.sv
// Drains a symbol FIFO, showing each symbol for HOLD then blanking for GAP.
// Optional PLAYER_SPACE_EN: SPACE_CODE plays as a blank slot.
module fifo_player
    import player_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int HOLD_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int CNT_W       = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_re,
    output logic [DATA_W-1:0] sym_out,
    output logic              sym_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sym_out_q, sym_out_d;
    logic              sym_valid_q, sym_valid_d;
    logic              done_q, done_d;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;

    cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = HOLD_LD;
        if (stop) begin
            state_d     = IDLE;
            sym_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (fifo_empty) done_d = 1'b1;
                        else            state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_d  = HOLD;
`ifdef PLAYER_SPACE_EN
                    if (fifo_data != DATA_W'(SPACE_CODE)) begin
                        sym_out_d   = fifo_data;
                        sym_valid_d = 1'b1;
                    end
`else
                    sym_out_d   = fifo_data;
                    sym_valid_d = 1'b1;
`endif
                end
                HOLD: begin
                    if (tmr_zero) begin
                        sym_valid_d = 1'b0;
                        tmr_load    = 1'b1;
                        tmr_val     = GAP_LD;
                        state_d     = GAP;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        if (fifo_empty) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
        end
    end

    assign fifo_re   = (state_q == FETCH) & ~fifo_empty;
    assign busy      = (state_q != IDLE);
    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fifo_player.sv
// Self-checking bench for fifo_player with HOLD=4, GAP=2 and a queue FIFO model.
module tb_fifo_player;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int PER  = HOLD + GAP + 2;
`ifdef PLAYER_SPACE_EN
    localparam bit SPACE_EN = 1'b1;
`else
    localparam bit SPACE_EN = 1'b0;
`endif

    typedef logic [3:0] sym_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       fifo_empty;
    logic [3:0] fifo_data;
    logic       fifo_re;
    logic [3:0] sym_out;
    logic       sym_valid;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         errors = 0;
    int         nreads = 0;
    sym_q_t     fq;
    sym_q_t     sq;
    logic [3:0] exp_sym = 4'h0;
    bit         force_empty = 1'b0;

    fifo_player #(
        .DATA_W     (4),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_re   (fifo_re),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then clock the FIFO model.
    task automatic cyc(input string tg, input bit ev, input bit er,
                       input bit ed, input bit eb, input bit csym);
        bit re;
        @(negedge clk);
        chk({tg, " sym_valid"}, sym_valid, ev);
        chk({tg, " fifo_re"}, fifo_re, er);
        chk({tg, " done"}, done, ed);
        chk({tg, " busy"}, busy, eb);
        if (csym) chk({tg, " sym_out"}, sym_out, exp_sym);
        re = fifo_re;
        @(posedge clk);
        #1;
        if (re && fq.size() != 0) begin
            fifo_data = fq.pop_front();
            nreads++;
        end
        fifo_empty = force_empty || (fq.size() == 0);
    endtask

    // Expected outputs at cycle c of a playback started in cycle 0.
    task automatic model(input int c, input sym_q_t s, output bit ev,
                         output bit er, output bit ed, output bit eb);
        int n;
        int k;
        n  = s.size();
        eb = (c >= 1) && (c <= PER * n);
        er = (c >= 1) && ((c - 1) % PER == 0) && ((c - 1) / PER < n);
        ed = (c == PER * n + 1);
        ev = 1'b0;
        if (c >= 3) begin
            k = (c - 3) / PER;
            if (k < n && (c - 3) % PER < HOLD &&
                !(SPACE_EN && s[k] == 4'hF)) begin
                ev      = 1'b1;
                exp_sym = s[k];
            end
        end
    endtask

    task automatic run_play(input string tg, input sym_q_t s);
        bit ev, er, ed, eb;
        fq         = s;
        nreads     = 0;
        fifo_empty = (fq.size() == 0);
        for (int c = 0; c <= PER * s.size() + 2; c++) begin
            start = (c == 0);
            model(c, s, ev, er, ed, eb);
            cyc($sformatf("%s c%0d", tg, c), ev, er, ed, eb, 1'b1);
        end
        start = 1'b0;
        chk({tg, " reads"}, nreads, s.size());
    endtask

    task automatic do_reset(input string tg);
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tg, " sym_valid"}, sym_valid, 1'b0);
        chk({tg, " fifo_re"}, fifo_re, 1'b0);
        chk({tg, " done"}, done, 1'b0);
        chk({tg, " busy"}, busy, 1'b0);
        chk({tg, " sym_out"}, sym_out, 4'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_sym = 4'h0;
    endtask

    initial begin
        bit ev, er, ed, eb;
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        sq.delete();
        sq.push_back(4'h3);
        sq.push_back(4'h7);
        run_play("p37", sq);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            sq.delete();
            for (int i = 0; i < n; i++) sq.push_back(4'($urandom_range(0, 15)));
            run_play($sformatf("rnd%0d", r), sq);
        end

        sq.delete();
        sq.push_back(4'h2);
        sq.push_back(4'hF);
        sq.push_back(4'h4);
        run_play("space", sq);

        fq.delete();
        fifo_empty = 1'b1;
        nreads     = 0;
        start      = 1'b1;
        cyc("empty c0", 0, 0, 0, 0, 1);
        start = 1'b0;
        cyc("empty c1", 0, 0, 1, 0, 1);
        cyc("empty c2", 0, 0, 0, 0, 1);
        chk("empty reads", nreads, 0);

        sq.delete();
        sq.push_back(4'h1);
        sq.push_back(4'h2);
        fq         = sq;
        fifo_empty = 1'b0;
        nreads     = 0;
        for (int c = 0; c <= 4; c++) begin
            start = (c == 0);
            stop  = (c == 4);
            model(c, sq, ev, er, ed, eb);
            cyc($sformatf("stop c%0d", c), ev, er, ed, eb, 1'b1);
        end
        stop = 1'b0;
        for (int c = 5; c <= 8; c++)
            cyc($sformatf("stop c%0d", c), 0, 0, 0, 0, 0);
        chk("stop reads", nreads, 1);
        fq.delete();
        do_reset("stop reset");

        sq.delete();
        sq.push_back(4'h6);
        fq         = sq;
        fifo_empty = 1'b0;
        nreads     = 0;
        start      = 1'b1;
        cyc("fe c0", 0, 0, 0, 0, 1);
        start       = 1'b0;
        force_empty = 1'b1;
        fifo_empty  = 1'b1;
        cyc("fe c1", 0, 0, 0, 1, 1);
        cyc("fe c2", 0, 0, 1, 0, 1);
        cyc("fe c3", 0, 0, 0, 0, 1);
        force_empty = 1'b0;
        chk("fe reads", nreads, 0);
        fq.delete();
        fifo_empty = 1'b1;

        sq.delete();
        sq.push_back(4'h9);
        fq         = sq;
        fifo_empty = 1'b0;
        nreads     = 0;
        for (int c = 0; c <= 6; c++) begin
            start = (c == 0);
            model(c, sq, ev, er, ed, eb);
            cyc($sformatf("gap c%0d", c), ev, er, ed, eb, 1'b1);
        end
        fq.delete();
        fifo_empty = 1'b1;
        do_reset("gap reset");

        sq.delete();
        sq.push_back(4'h5);
        run_play("p5", sq);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
